// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and the in-flight tag slot record
package pipe_pkg;
   localparam int REG_W = 4;
   localparam logic [REG_W-1:0] PC_REG = 4'd15;
   localparam int FWD_RF = 0;
   localparam int STG_EX = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB = 2;
   typedef struct packed {
      logic             valid;
      logic             dst_en;
      logic [REG_W-1:0] dst;
      logic             is_load;
      logic             flag_set;
   } slot_t;
endpackage

// File: rtl/hazard_tag_slot.sv
// hazard_tag_slot: one in-flight destination tag plus its per-source comparators
module hazard_tag_slot
   import pipe_pkg::*;
#(
   parameter int NUM_SRC = 3
) (
   input  logic                     CLK,
   input  logic                     CLR,
   input  slot_t                    slot_d,
   input  logic [NUM_SRC-1:0]       src_en_i,
   input  logic [NUM_SRC*REG_W-1:0] src_i,
   output slot_t                    slot_o,
   output logic [NUM_SRC-1:0]       match_o
);
   slot_t slot_q;
   // the slot advances every edge and is never frozen
   always_ff @(posedge CLK or negedge CLR)
      if (!CLR) slot_q <= '0;
      else slot_q <= slot_d;
   // R15 reads come from the PC path, so they never match
   always_comb
      for (int i = 0; i < NUM_SRC; i++)
         match_o[i] = src_en_i[i] && slot_q.valid && slot_q.dst_en &&
                      slot_q.dst == src_i[i*REG_W +: REG_W] && src_i[i*REG_W +: REG_W] != PC_REG;
   assign slot_o = slot_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects plus load-use/flag stall, flush and stall counter
module hazard_scoreboard
   import pipe_pkg::*;
#(
   parameter  int NUM_SRC    = 3,
   parameter  int NUM_STAGES = 3,
   parameter  int LOAD_READY = 1,
   parameter  int FLAG_READY = 1,
   parameter  int CNT_W      = 16,
   localparam int FWD_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic                     CLK,
   input  logic                     CLR,
   input  logic                     id_valid,
   input  logic [NUM_SRC-1:0]       id_src_en,
   input  logic [NUM_SRC*REG_W-1:0] id_src,
   input  logic                     id_dst_en,
   input  logic [REG_W-1:0]         id_dst,
   input  logic                     id_is_load,
   input  logic                     id_flag_set,
   input  logic                     id_flag_use,
   input  logic                     br_taken,
   input  logic                     perf_clr,
   output logic [NUM_SRC*FWD_W-1:0] fwd_sel,
   output logic                     stall_o,
   output logic                     bubble_o,
   output logic                     flush_o,
   output logic [CNT_W-1:0]         stall_count
);
   slot_t              slot_d [NUM_STAGES];
   slot_t              slot_q [NUM_STAGES];
   logic [NUM_SRC-1:0] match  [NUM_STAGES];
   logic               load_use, flag_hz;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
      hazard_tag_slot #(.NUM_SRC(NUM_SRC)) u_slot (
         .CLK      (CLK),
         .CLR      (CLR),
         .slot_d   (slot_d[g]),
         .src_en_i (id_src_en),
         .src_i    (id_src),
         .slot_o   (slot_q[g]),
         .match_o  (match[g])
      );
   end
   // ID enters slot 0 unless held or killed; older slots shift toward WB
   always_comb begin
      slot_d[0] = '{valid: id_valid && !stall_o && !br_taken, dst_en: id_dst_en, dst: id_dst,
                    is_load: id_is_load, flag_set: id_flag_set};
      for (int k = 1; k < NUM_STAGES; k++) slot_d[k] = slot_q[k-1];
   end
   // youngest matching stage wins per source; a load winner too early means load-use
   always_comb begin
      logic [FWD_W-1:0] sel;
      logic             ld;
      fwd_sel  = '0;
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         sel = FWD_W'(FWD_RF);
         ld  = 1'b0;
         for (int k = NUM_STAGES - 1; k >= 0; k--)
            if (match[k][i]) begin
               sel = FWD_W'(k + 1);
               ld  = slot_q[k].is_load && k < LOAD_READY;
            end
         fwd_sel[i*FWD_W +: FWD_W] = sel;
         load_use = load_use || ld;
      end
   end
   // flag results from stages before FLAG_READY are not yet visible to ID
   always_comb begin
      flag_hz = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++)
         if (k < FLAG_READY && slot_q[k].valid && slot_q[k].flag_set) flag_hz = 1'b1;
   end
   assign stall_o     = id_valid && (load_use || (id_flag_use && flag_hz)) && !br_taken;
   assign bubble_o    = stall_o;
   assign flush_o     = br_taken;
   assign cnt_d       = perf_clr ? '0 : (stall_o && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   assign stall_count = cnt_q;
   // saturating stall-cycle counter
   always_ff @(posedge CLK or negedge CLR)
      if (!CLR) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus hand sequences for stall corners
module tb_hazard_scoreboard;
   logic        CLK = 1'b0, CLR = 1'b0;
   logic        id_valid = 1'b0, id_dst_en = 1'b0, id_is_load = 1'b0;
   logic        id_flag_set = 1'b0, id_flag_use = 1'b0, br_taken = 1'b0, perf_clr = 1'b0;
   logic [2:0]  id_src_en = '0;
   logic [11:0] id_src = '0;
   logic [3:0]  id_dst = '0;
   logic [5:0]  fwd_sel;
   logic        stall_o, bubble_o, flush_o;
   logic [3:0]  stall_count;
   always #5 CLK = ~CLK;
   hazard_scoreboard #(.CNT_W(4)) dut (
      .CLK(CLK), .CLR(CLR), .id_valid(id_valid), .id_src_en(id_src_en), .id_src(id_src),
      .id_dst_en(id_dst_en), .id_dst(id_dst), .id_is_load(id_is_load), .id_flag_set(id_flag_set),
      .id_flag_use(id_flag_use), .br_taken(br_taken), .perf_clr(perf_clr), .fwd_sel(fwd_sel),
      .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o), .stall_count(stall_count)
   );
   typedef struct {
      logic v; logic [2:0] se; logic [11:0] s; logic de; logic [3:0] d;
      logic ld, fs, fu, br, pc;
      logic [5:0] efwd; logic est; logic [3:0] ecnt;
   } vec_t;
   int   n_vec = 0, n_err = 0;
   vec_t tbl[$];
   function automatic vec_t mk(logic v, logic [2:0] se, logic [11:0] s, logic de, logic [3:0] d,
                               logic ld, logic fs, logic fu, logic br, logic pc,
                               logic [5:0] efwd, logic est, logic [3:0] ecnt);
      vec_t x;
      x.v = v; x.se = se; x.s = s; x.de = de; x.d = d; x.ld = ld; x.fs = fs; x.fu = fu;
      x.br = br; x.pc = pc; x.efwd = efwd; x.est = est; x.ecnt = ecnt;
      return x;
   endfunction
   function automatic vec_t nop(logic [3:0] c);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c);
   endfunction
   function automatic vec_t ldr(logic [3:0] c);
      return mk(1, 3'b001, 12'h004, 1, 4'd2, 1, 0, 0, 0, 0, 6'd0, 0, c);
   endfunction
   function automatic vec_t add(logic [5:0] f, logic st, logic pc, logic [3:0] c);
      return mk(1, 3'b011, 12'h042, 1, 4'd3, 0, 0, 0, 0, pc, f, st, c);
   endfunction
   task automatic check(input vec_t x, input string nm);
      n_vec++;
      if (fwd_sel !== x.efwd) begin n_err++; $display("FAIL %s fwd_sel got %b want %b", nm, fwd_sel, x.efwd); end
      if (stall_o !== x.est) begin n_err++; $display("FAIL %s stall_o got %b want %b", nm, stall_o, x.est); end
      if (bubble_o !== x.est) begin n_err++; $display("FAIL %s bubble_o got %b want %b", nm, bubble_o, x.est); end
      if (flush_o !== x.br) begin n_err++; $display("FAIL %s flush_o got %b want %b", nm, flush_o, x.br); end
      if (stall_count !== x.ecnt) begin n_err++; $display("FAIL %s stall_count got %0d want %0d", nm, stall_count, x.ecnt); end
   endtask
   task automatic cyc(input vec_t x, input string nm);
      @(negedge CLK);
      id_valid = x.v; id_src_en = x.se; id_src = x.s; id_dst_en = x.de; id_dst = x.d;
      id_is_load = x.ld; id_flag_set = x.fs; id_flag_use = x.fu; br_taken = x.br; perf_clr = x.pc;
      #1;
      check(x, nm);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      logic [3:0] c;
      for (int i = 0; i < 4; i++)
         cyc(mk(1'($urandom), 3'($urandom), 12'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 6'd0, 0, 0), $sformatf("reset%0d", i));
      @(negedge CLK);
      CLR = 1'b1; id_valid = 1'b0; br_taken = 1'b0; perf_clr = 1'b0;
      tbl.push_back(nop(0));
      tbl.push_back(mk(1, 3'b011, 12'h065, 1, 4'd1, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
      tbl.push_back(mk(1, 3'b011, 12'h031, 1, 4'd2, 0, 0, 0, 0, 0, 6'b000001, 0, 0));
      tbl.push_back(mk(1, 3'b011, 12'h021, 0, 4'd0, 0, 0, 0, 0, 0, 6'b000110, 0, 0));
      tbl.push_back(mk(1, 3'b011, 12'h021, 0, 4'd0, 0, 0, 0, 0, 0, 6'b001011, 0, 0));
      tbl.push_back(mk(1, 3'b101, 12'h201, 0, 4'd0, 0, 0, 0, 0, 0, 6'b110000, 0, 0));
      tbl.push_back(nop(0));
      tbl.push_back(nop(0));
      tbl.push_back(nop(0));
      tbl.push_back(ldr(0));
      tbl.push_back(add(6'b000001, 1, 0, 0));
      tbl.push_back(add(6'b000010, 0, 0, 1));
      tbl.push_back(mk(1, 3'b000, 12'h000, 1, 4'd1, 0, 0, 0, 0, 0, 6'b000000, 0, 1));
      tbl.push_back(mk(1, 3'b001, 12'h007, 1, 4'd1, 0, 0, 0, 0, 0, 6'b000000, 0, 1));
      tbl.push_back(mk(1, 3'b001, 12'h001, 0, 4'd0, 0, 0, 0, 0, 0, 6'b000001, 0, 1));
      tbl.push_back(nop(1));
      tbl.push_back(nop(1));
      tbl.push_back(nop(1));
      tbl.push_back(mk(1, 3'b001, 12'h001, 0, 4'd0, 0, 1, 0, 0, 0, 6'b000000, 0, 1));
      tbl.push_back(mk(1, 3'b000, 12'h000, 0, 4'd0, 0, 0, 1, 0, 0, 6'b000000, 1, 1));
      tbl.push_back(mk(1, 3'b000, 12'h000, 0, 4'd0, 0, 0, 1, 0, 0, 6'b000000, 0, 2));
      tbl.push_back(ldr(2));
      tbl.push_back(mk(1, 3'b001, 12'h002, 1, 4'd5, 0, 0, 0, 1, 0, 6'b000001, 0, 2));
      tbl.push_back(mk(1, 3'b011, 12'h052, 0, 4'd0, 0, 0, 0, 0, 0, 6'b000010, 0, 2));
      tbl.push_back(nop(2));
      tbl.push_back(nop(2));
      tbl.push_back(mk(1, 3'b000, 12'h000, 1, 4'd15, 1, 0, 0, 0, 0, 6'b000000, 0, 2));
      tbl.push_back(mk(1, 3'b001, 12'h00F, 0, 4'd0, 0, 0, 0, 0, 0, 6'b000000, 0, 2));
      tbl.push_back(ldr(2));
      tbl.push_back(mk(0, 3'b001, 12'h002, 0, 4'd0, 0, 0, 0, 0, 0, 6'b000001, 0, 2));
      tbl.push_back(nop(2));
      foreach (tbl[i]) cyc(tbl[i], $sformatf("vec%0d", i));
      c = 4'd2;
      for (int i = 0; i < 14; i++) begin
         cyc(ldr(c), $sformatf("sat_ldr%0d", i));
         cyc(add(6'd1, 1, 0, c), $sformatf("sat_stall%0d", i));
         c = (c == 4'd15) ? c : c + 4'd1;
         cyc(add(6'd2, 0, 0, c), $sformatf("sat_go%0d", i));
      end
      cyc(ldr(15), "clr_ldr");
      cyc(add(6'd1, 1, 1, 15), "clr_stall");
      cyc(add(6'd2, 0, 0, 0), "clr_after");
      cyc(ldr(0), "rst_ldr");
      cyc(add(6'd1, 1, 0, 0), "rst_stall");
      #1 CLR = 1'b0;
      #1 check(add(6'd0, 0, 0, 0), "rst_async");
      @(negedge CLK);
      CLR = 1'b1;
      cyc(add(6'd0, 0, 0, 0), "rst_proceed");
      cyc(mk(1, 3'b001, 12'h003, 0, 4'd0, 0, 0, 0, 0, 0, 6'd1, 0, 0), "rst_resume");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
